// File: rtl/ptw_arb_pkg.sv
// Shared types and constants for the two-requester page-table-walk arbiter.
package ptw_arb_pkg;

  localparam int VPN_W = 27;
  localparam int PPN_W = 21;
  localparam int PTE_W = PPN_W + 7;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    logic             u;
    logic             ae_ptw;
    logic             ae_final;
    logic             pf;
    logic             gf;
    logic             sx;
    logic             px;
  } pte_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Timeout counter is at least 8 bits wide, wider only for large timeouts.
  function automatic int cnt_width(input int unsigned t);
    return (t > 255) ? $clog2(t + 1) : 8;
  endfunction

  // Refill entry returned when the walker never answers.
  function automatic pte_entry_t access_fault_entry();
    pte_entry_t e;
    e        = '0;
    e.ae_ptw = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/ptw_rr_arb2.sv
// Two-way round-robin grant: ptr names the requester favoured this cycle.
module ptw_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (ptr == 1'b0) begin
      if (valid[0])      grant = 2'b01;
      else if (valid[1]) grant = 2'b10;
    end else begin
      if (valid[1])      grant = 2'b10;
      else if (valid[0]) grant = 2'b01;
    end
  end

endmodule

// File: rtl/ptw_arbiter.sv
// Arbitrates ITLB/DTLB misses onto one page-table walker, one walk at a time,
// with a response timeout and flush handling. dbg_state mirrors the FSM.
module ptw_arbiter
  import ptw_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         io_req_valid,
  output logic [1:0]         io_req_ready,
  input  logic [2*VPN_W-1:0] io_req_vpn,
  output logic               io_ptw_req_valid,
  input  logic               io_ptw_req_ready,
  output logic [VPN_W-1:0]   io_ptw_req_vpn,
  input  logic               io_ptw_resp_valid,
  input  logic [PTE_W-1:0]   io_ptw_resp_entry,
  output logic [1:0]         io_resp_valid,
  output logic [PTE_W-1:0]   io_resp_entry,
  input  logic               io_flush,
  output logic               io_busy,
  output state_t             dbg_state
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready and is held until the transfer.
  state_t           state_q, state_d;
  logic             ptr_q;
  logic             owner_q;
  logic [VPN_W-1:0] vpn_q;
  logic [CNT_W-1:0] cnt_q;
  logic             flush_q;
  logic [1:0]       resp_valid_q;
  pte_entry_t       resp_entry_q;

  logic [1:0] grant;
  logic       grant_fire;
  logic       issue_fire;
  logic       deliver;
  logic       timeout;

  ptw_rr_arb2 u_rr (
    .valid (io_req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    io_req_ready = 2'b00;
    grant_fire   = 1'b0;
    issue_fire   = 1'b0;
    deliver      = 1'b0;
    timeout      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Gated by reset so nothing looks accepted while the block is held.
        io_req_ready = reset_n ? grant : 2'b00;
        if (|grant) begin
          grant_fire = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (io_ptw_req_ready) begin
          issue_fire = 1'b1;
          state_d    = (flush_q || io_flush) ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (io_flush && io_ptw_resp_valid) begin
          state_d = ST_IDLE;
        end else if (io_flush) begin
          state_d = ST_DRAIN;
        end else if (io_ptw_resp_valid) begin
          deliver = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q <= CNT_W'(1)) begin
          // The counter hits zero on this edge: WAIT lasts TIMEOUT_CYCLES cycles.
          timeout = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (io_ptw_resp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= 1'b0;
      owner_q      <= 1'b0;
      vpn_q        <= '0;
      cnt_q        <= '0;
      flush_q      <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_entry_q <= '0;
    end else begin
      resp_valid_q <= 2'b00;
      if (grant_fire) begin
        owner_q <= grant[1];
        ptr_q   <= ~grant[1];
        vpn_q   <= grant[1] ? io_req_vpn[2*VPN_W-1:VPN_W] : io_req_vpn[VPN_W-1:0];
      end
      if (state_q == ST_ISSUE) flush_q <= issue_fire ? 1'b0 : (flush_q | io_flush);
      if (issue_fire) begin
        cnt_q <= CNT_W'(TIMEOUT_CYCLES);
      end else if (state_q == ST_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (deliver) begin
        resp_valid_q <= owner_q ? 2'b10 : 2'b01;
        resp_entry_q <= io_ptw_resp_entry;
      end else if (timeout) begin
        resp_valid_q <= owner_q ? 2'b10 : 2'b01;
        resp_entry_q <= access_fault_entry();
      end
    end
  end

  assign io_ptw_req_valid = (state_q == ST_ISSUE);
  assign io_ptw_req_vpn   = vpn_q;
  assign io_resp_valid    = resp_valid_q;
  assign io_resp_entry    = resp_entry_q;
  assign io_busy          = (state_q != ST_IDLE);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Bench for ptw_arbiter: directed vector table, corner sequences, and a
// randomized run checked against a transaction-level reference model.
module tb_ptw_arbiter;
  import ptw_arb_pkg::*;

  localparam int T = 4;
  localparam logic [27:0] E1   = {21'h00042, 7'b0000001};
  localparam logic [27:0] E2   = {21'h1ABCD, 7'b1000010};
  localparam logic [27:0] AE   = {21'h00000, 7'b0100000};
  localparam logic [27:0] JUNK = 28'hFFFFFFF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  io_req_valid = 2'b00;
  logic [1:0]  io_req_ready;
  logic [53:0] io_req_vpn = '0;
  logic        io_ptw_req_valid;
  logic        io_ptw_req_ready = 1'b0;
  logic [26:0] io_ptw_req_vpn;
  logic        io_ptw_resp_valid = 1'b0;
  logic [27:0] io_ptw_resp_entry = '0;
  logic [1:0]  io_resp_valid;
  logic [27:0] io_resp_entry;
  logic        io_flush = 1'b0;
  logic        io_busy;
  state_t      dbg_state;

  int checks = 0;
  int failures = 0;
  logic [28:0] exp_q[$];

  ptw_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .io_req_valid      (io_req_valid),
    .io_req_ready      (io_req_ready),
    .io_req_vpn        (io_req_vpn),
    .io_ptw_req_valid  (io_ptw_req_valid),
    .io_ptw_req_ready  (io_ptw_req_ready),
    .io_ptw_req_vpn    (io_ptw_req_vpn),
    .io_ptw_resp_valid (io_ptw_resp_valid),
    .io_ptw_resp_entry (io_ptw_resp_entry),
    .io_resp_valid     (io_resp_valid),
    .io_resp_entry     (io_resp_entry),
    .io_flush          (io_flush),
    .io_busy           (io_busy),
    .dbg_state         (dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] e_ready, input logic e_pv,
                            input logic [26:0] e_vpn, input logic [1:0] e_rv,
                            input logic [27:0] e_re, input logic e_busy, input logic [1:0] e_st);
    check({tag, ".req_ready"}, 64'(io_req_ready), 64'(e_ready));
    check({tag, ".ptw_valid"}, 64'(io_ptw_req_valid), 64'(e_pv));
    check({tag, ".ptw_vpn"}, 64'(io_ptw_req_vpn), 64'(e_vpn));
    check({tag, ".resp_valid"}, 64'(io_resp_valid), 64'(e_rv));
    check({tag, ".resp_entry"}, 64'(io_resp_entry), 64'(e_re));
    check({tag, ".busy"}, 64'(io_busy), 64'(e_busy));
    check({tag, ".state"}, 64'(dbg_state), 64'(e_st));
  endtask

  // Driver: new inputs 1 ns after the rising edge, outputs sampled on the falling edge.
  task automatic drive(input logic [1:0] v, input logic [26:0] v0, input logic [26:0] v1,
                       input logic rdy, input logic rv, input logic [27:0] re, input logic fl);
    io_req_valid      = v;
    io_req_vpn        = {v1, v0};
    io_ptw_req_ready  = rdy;
    io_ptw_resp_valid = rv;
    io_ptw_resp_entry = re;
    io_flush          = fl;
  endtask

  task automatic step(input logic [1:0] v, input logic [26:0] v0, input logic [26:0] v1,
                      input logic rdy, input logic rv, input logic [27:0] re, input logic fl);
    @(posedge clock);
    #1;
    drive(v, v0, v1, rdy, rv, re, fl);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    drive(2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Reference model
  int          m_phase;  // 0 free, 1 offering walk, 2 awaiting result, 3 swallowing one result
  int          m_ptr, m_owner, m_left;
  bit          m_fl;
  logic [26:0] m_vpn;
  logic [1:0]  m_pulse;
  logic [27:0] m_entry;

  function automatic logic [1:0] rr_pick(input logic [1:0] v, input int p);
    for (int k = 0; k < 2; k++) begin
      int idx;
      idx = (p + k) % 2;
      if (v[idx]) return 2'b01 << idx;
    end
    return 2'b00;
  endfunction

  task automatic model_deliver(input logic [27:0] e);
    m_pulse = (m_owner == 1) ? 2'b10 : 2'b01;
    m_entry = e;
    exp_q.push_back({(m_owner == 1), e});
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic        ptw_ready;
    logic        resp_v;
    logic [27:0] resp_e;
    logic [1:0]  e_ready;
    logic        e_pv;
    logic [26:0] e_vpn;
    logic [1:0]  e_rv;
    logic [27:0] e_re;
    logic        e_busy;
    logic [1:0]  e_st;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v, input logic rdy, input logic rv,
                              input logic [27:0] re, input logic [1:0] er, input logic epv,
                              input logic [26:0] evpn, input logic [1:0] erv,
                              input logic [27:0] ere, input logic eb, input logic [1:0] est);
    vec_t r;
    r.valid = v; r.ptw_ready = rdy; r.resp_v = rv; r.resp_e = re;
    r.e_ready = er; r.e_pv = epv; r.e_vpn = evpn; r.e_rv = erv;
    r.e_re = ere; r.e_busy = eb; r.e_st = est;
    return r;
  endfunction

  vec_t tbl[13];

  initial begin
    logic [1:0] cv [4];
    logic [1:0] ce [4];

    // Reset state
    drive(2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) @(negedge clock);
    check_outs("reset", 2'b00, 1'b0, 27'h0, 2'b00, 28'h0, 1'b0, 2'd0);
    reset_n = 1'b1;

    // Combinational grant with the pointer at its reset value
    cv = '{2'b00, 2'b01, 2'b10, 2'b11};
    ce = '{2'b00, 2'b01, 2'b10, 2'b01};
    @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      #1;
      io_req_valid = cv[i];
      #1;
      check($sformatf("rr_idle[%0d]", i), 64'(io_req_ready), 64'(ce[i]));
    end
    io_req_valid = 2'b00;

    // Table: both requesters, stalled walker, owner-0 and owner-1 refills
    tbl[0] = mk(2'b11, 0, 0, '0, 2'b01, 0, 27'h0,    2'b00, 28'h0, 0, 2'd0);
    for (int i = 1; i <= 5; i++)
      tbl[i] = mk(2'b10, 0, 0, '0, 2'b00, 1, 27'h1234, 2'b00, 28'h0, 1, 2'd1);
    tbl[6]  = mk(2'b10, 1, 0, '0, 2'b00, 1, 27'h1234, 2'b00, 28'h0, 1, 2'd1);
    tbl[7]  = mk(2'b10, 0, 1, E1, 2'b00, 0, 27'h1234, 2'b00, 28'h0, 1, 2'd2);
    tbl[8]  = mk(2'b10, 0, 0, '0, 2'b10, 0, 27'h1234, 2'b01, E1,    0, 2'd0);
    tbl[9]  = mk(2'b00, 1, 0, '0, 2'b00, 1, 27'h5678, 2'b00, E1,    1, 2'd1);
    tbl[10] = mk(2'b00, 0, 1, E2, 2'b00, 0, 27'h5678, 2'b00, E1,    1, 2'd2);
    tbl[11] = mk(2'b00, 0, 0, '0, 2'b00, 0, 27'h5678, 2'b10, E2,    0, 2'd0);
    tbl[12] = mk(2'b00, 0, 0, '0, 2'b00, 0, 27'h5678, 2'b00, E2,    0, 2'd0);
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].valid, 27'h1234, 27'h5678, tbl[i].ptw_ready, tbl[i].resp_v, tbl[i].resp_e, 1'b0);
      check_outs($sformatf("tbl[%0d]", i), tbl[i].e_ready, tbl[i].e_pv, tbl[i].e_vpn,
                 tbl[i].e_rv, tbl[i].e_re, tbl[i].e_busy, tbl[i].e_st);
    end

    // Timeout after T WAIT cycles, late response swallowed in DRAIN
    step(2'b01, 27'hABC, 27'h0, 0, 0, '0, 0);
    check_outs("to.grant", 2'b01, 0, 27'h5678, 2'b00, E2, 0, 2'd0);
    step(2'b00, 27'h0, 27'h0, 1, 0, '0, 0);
    check_outs("to.issue", 2'b00, 1, 27'hABC, 2'b00, E2, 1, 2'd1);
    for (int i = 0; i < T; i++) begin
      step(2'b00, 27'h0, 27'h0, 0, 0, '0, 0);
      check_outs($sformatf("to.wait[%0d]", i), 2'b00, 0, 27'hABC, 2'b00, E2, 1, 2'd2);
    end
    step(2'b00, 27'h0, 27'h0, 0, 1, JUNK, 0);
    check_outs("to.pulse", 2'b00, 0, 27'hABC, 2'b01, AE, 1, 2'd3);
    step(2'b00, 27'h0, 27'h0, 0, 0, '0, 0);
    check_outs("to.idle", 2'b00, 0, 27'hABC, 2'b00, AE, 0, 2'd0);

    // Flush while offering the walk: result discarded
    step(2'b10, 27'h0, 27'h777, 0, 0, '0, 0);
    check_outs("fi.grant", 2'b10, 0, 27'hABC, 2'b00, AE, 0, 2'd0);
    step(2'b00, 27'h0, 27'h0, 0, 0, '0, 1);
    check_outs("fi.flush", 2'b00, 1, 27'h777, 2'b00, AE, 1, 2'd1);
    step(2'b00, 27'h0, 27'h0, 1, 0, '0, 0);
    check_outs("fi.accept", 2'b00, 1, 27'h777, 2'b00, AE, 1, 2'd1);
    step(2'b00, 27'h0, 27'h0, 0, 1, JUNK, 0);
    check_outs("fi.drain", 2'b00, 0, 27'h777, 2'b00, AE, 1, 2'd3);
    step(2'b00, 27'h0, 27'h0, 0, 0, '0, 0);
    check_outs("fi.idle", 2'b00, 0, 27'h777, 2'b00, AE, 0, 2'd0);
    step(2'b00, 27'h0, 27'h0, 0, 0, '0, 0);
    check_outs("fi.quiet", 2'b00, 0, 27'h777, 2'b00, AE, 0, 2'd0);

    // Flush in WAIT, then flush coinciding with a response
    step(2'b01, 27'h111, 27'h0, 0, 0, '0, 0);
    check_outs("fw.grant", 2'b01, 0, 27'h777, 2'b00, AE, 0, 2'd0);
    step(2'b00, 27'h0, 27'h0, 1, 0, '0, 0);
    check_outs("fw.issue", 2'b00, 1, 27'h111, 2'b00, AE, 1, 2'd1);
    step(2'b00, 27'h0, 27'h0, 0, 0, '0, 1);
    check_outs("fw.flush", 2'b00, 0, 27'h111, 2'b00, AE, 1, 2'd2);
    step(2'b00, 27'h0, 27'h0, 0, 1, JUNK, 0);
    check_outs("fw.drain", 2'b00, 0, 27'h111, 2'b00, AE, 1, 2'd3);
    step(2'b01, 27'h111, 27'h0, 0, 0, '0, 0);
    check_outs("fr.grant", 2'b01, 0, 27'h111, 2'b00, AE, 0, 2'd0);
    step(2'b00, 27'h0, 27'h0, 1, 0, '0, 0);
    check_outs("fr.issue", 2'b00, 1, 27'h111, 2'b00, AE, 1, 2'd1);
    step(2'b00, 27'h0, 27'h0, 0, 1, E2, 1);
    check_outs("fr.both", 2'b00, 0, 27'h111, 2'b00, AE, 1, 2'd2);
    step(2'b00, 27'h0, 27'h0, 0, 0, '0, 0);
    check_outs("fr.idle", 2'b00, 0, 27'h111, 2'b00, AE, 0, 2'd0);

    // Reset in WAIT: outputs clear at once, stale response ignored
    step(2'b01, 27'h222, 27'h0, 0, 0, '0, 0);
    check_outs("rw.grant", 2'b01, 0, 27'h111, 2'b00, AE, 0, 2'd0);
    step(2'b00, 27'h0, 27'h0, 1, 0, '0, 0);
    step(2'b00, 27'h0, 27'h0, 0, 0, '0, 0);
    check_outs("rw.wait", 2'b00, 0, 27'h222, 2'b00, AE, 1, 2'd2);
    @(posedge clock);
    #1;
    drive(2'b11, 27'h1, 27'h2, 1'b1, 1'b0, '0, 1'b0);
    reset_n = 1'b0;
    #1;
    check_outs("rw.asserted", 2'b00, 0, 27'h0, 2'b00, 28'h0, 0, 2'd0);
    io_req_valid = 2'b00;
    @(negedge clock);
    reset_n = 1'b1;
    step(2'b00, 27'h0, 27'h0, 0, 1, E2, 0);
    check_outs("rw.stale", 2'b00, 0, 27'h0, 2'b00, 28'h0, 0, 2'd0);
    step(2'b11, 27'h5, 27'h6, 0, 0, '0, 0);
    check_outs("rw.ptr", 2'b01, 0, 27'h0, 2'b00, 28'h0, 0, 2'd0);

    // Randomized run against the reference model
    do_reset();
    m_phase = 0; m_ptr = 0; m_owner = 0; m_left = 0; m_fl = 0;
    m_vpn = '0; m_pulse = 2'b00; m_entry = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [1:0]  r_v;
      logic [26:0] r_v0, r_v1;
      logic        r_rdy, r_rv, r_fl;
      logic [27:0] r_re;
      logic [1:0]  e_ready;
      logic [28:0] got;
      r_v   = 2'($urandom_range(0, 3));
      r_v0  = 27'($urandom);
      r_v1  = 27'($urandom);
      r_rdy = ($urandom_range(0, 1) == 1);
      r_rv  = ($urandom_range(0, 9) < 3);
      r_re  = 28'($urandom);
      r_fl  = ($urandom_range(0, 19) == 0);
      step(r_v, r_v0, r_v1, r_rdy, r_rv, r_re, r_fl);

      e_ready = (m_phase == 0) ? rr_pick(r_v, m_ptr) : 2'b00;
      check("rnd.req_ready", 64'(io_req_ready), 64'(e_ready));
      check("rnd.ptw_valid", 64'(io_ptw_req_valid), 64'(m_phase == 1));
      if (m_phase == 1) check("rnd.ptw_vpn", 64'(io_ptw_req_vpn), 64'(m_vpn));
      check("rnd.busy", 64'(io_busy), 64'(m_phase != 0));
      check("rnd.resp_valid", 64'(io_resp_valid), 64'(m_pulse));
      check("rnd.resp_entry", 64'(io_resp_entry), 64'(m_entry));
      if (io_resp_valid != 2'b00) begin
        got = {io_resp_valid[1], io_resp_entry};
        if (exp_q.size() == 0) begin
          check("rnd.sb_unexpected", 64'(got), 64'h0);
        end else begin
          check("rnd.sb_resp", 64'(got), 64'(exp_q.pop_front()));
        end
      end

      m_pulse = 2'b00;
      case (m_phase)
        0: if (e_ready != 2'b00) begin
          m_owner = e_ready[1] ? 1 : 0;
          m_vpn   = (m_owner == 1) ? r_v1 : r_v0;
          m_ptr   = 1 - m_owner;
          m_fl    = 0;
          m_phase = 1;
        end
        1: begin
          if (r_fl) m_fl = 1;
          if (r_rdy) begin
            m_phase = m_fl ? 3 : 2;
            m_left  = T;
            m_fl    = 0;
          end
        end
        2: begin
          if (r_fl && r_rv) begin
            m_phase = 0;
          end else if (r_fl) begin
            m_phase = 3;
          end else if (r_rv) begin
            model_deliver(r_re);
            m_phase = 0;
          end else begin
            m_left--;
            if (m_left <= 0) begin
              model_deliver(AE);
              m_phase = 3;
            end
          end
        end
        default: if (r_rv) m_phase = 0;
      endcase
    end
    step(2'b00, 27'h0, 27'h0, 0, 0, '0, 0);
    if (io_resp_valid != 2'b00 && exp_q.size() != 0)
      check("rnd.sb_last", 64'({io_resp_valid[1], io_resp_entry}), 64'(exp_q.pop_front()));
    check("rnd.sb_drained", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
